// File: rtl/uart_birth_rx_if.sv
// Signal bundle between the UART RX pin / consumers and the birthday decoder.
// The receiver takes the slave modport; whoever drives the line takes master.
interface uart_birth_rx_if;
  logic        rx;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [15:0] date_year;
  logic [7:0]  date_month;
  logic [7:0]  date_day;
  logic        date_valid;
  logic        date_match;
  logic        err;
  logic        busy;

  modport master (
    output rx,
    input  byte_data, byte_valid, date_year, date_month, date_day,
    input  date_valid, date_match, err, busy
  );

  modport slave (
    input  rx,
    output byte_data, byte_valid, date_year, date_month, date_day,
    output date_valid, date_match, err, busy
  );
endinterface

// File: rtl/uart_birth_rx.sv
// UART 8N1 receiver that decodes an ASCII "YYYYMMDD" stream into packed BCD and
// compares it against a build-time expected date.
module uart_birth_rx #(
  parameter logic [11:0] baud_cnt_max = 12'd433,
  parameter logic [15:0] birth_year   = 16'h2000,
  parameter logic [7:0]  birth_month  = 8'h10,
  parameter logic [7:0]  birth_day    = 8'h29
) (
  input logic            clk,
  input logic            rst_n,
  uart_birth_rx_if.slave bus
);

  localparam logic [11:0] Half = baud_cnt_max >> 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e state_q, state_d;

  logic        rx_meta_q, rx_s_q, rx_d_q;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;

  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        err_q, err_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [15:0] date_year_q, date_year_d;
  logic [7:0]  date_month_q, date_month_d;
  logic [7:0]  date_day_q, date_day_d;
  logic        date_valid_q, date_valid_d;
  logic        date_match_q, date_match_d;

  logic start_edge, at_half, at_max;
  logic frame_good, frame_err, false_start;
  logic is_digit;

  // Synchroniser resets to the idle level so leaving reset never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign start_edge = rx_d_q & ~rx_s_q;
  assign at_half    = (baud_cnt_q == Half);
  assign at_max     = (baud_cnt_q == baud_cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      StStart: begin
        if (at_half && rx_s_q) begin
          state_d = StIdle;
        end else if (at_max) begin
          state_d = StData;
        end
      end
      StData:  if (at_max && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:  if (at_half) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_good  = 1'b0;
    frame_err   = 1'b0;
    false_start = 1'b0;

    // The counter only runs inside a frame; any path back to idle parks it at 0.
    if ((state_q == StIdle) || (state_d == StIdle) || at_max) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 12'd1;
    end

    unique case (state_q)
      StStart: begin
        false_start = at_half & rx_s_q;
        if (at_max) bit_idx_d = '0;
      end
      StData: begin
        if (at_half) shift_d[bit_idx_q] = rx_s_q;
        if (at_max) bit_idx_d = bit_idx_q + 3'd1;
      end
      StStop: begin
        frame_good = at_half & rx_s_q;
        frame_err  = at_half & ~rx_s_q;
      end
      default: ;
    endcase
  end

  assign is_digit = (byte_data_q >= 8'h30) && (byte_data_q <= 8'h39);

  always_comb begin
    byte_valid_d = frame_good;
    byte_data_d  = frame_good ? shift_q : byte_data_q;
    err_d        = frame_err | false_start;
    digit_cnt_d  = digit_cnt_q;
    shreg_d      = shreg_q;
    date_year_d  = date_year_q;
    date_month_d = date_month_q;
    date_day_d   = date_day_q;
    date_valid_d = 1'b0;
    date_match_d = date_match_q;

    // Digit screening runs one cycle behind byte_valid, off the registered byte.
    if (byte_valid_q) begin
      if (is_digit) begin
        shreg_d = {shreg_q[27:0], byte_data_q[3:0]};
        if (digit_cnt_q == 3'd7) begin
          date_year_d  = shreg_d[31:16];
          date_month_d = shreg_d[15:8];
          date_day_d   = shreg_d[7:0];
          date_match_d = ({shreg_d[31:16], shreg_d[15:8], shreg_d[7:0]} ==
                          {birth_year, birth_month, birth_day});
          date_valid_d = 1'b1;
          digit_cnt_d  = '0;
        end else begin
          digit_cnt_d = digit_cnt_q + 3'd1;
        end
      end else begin
        err_d       = 1'b1;
        digit_cnt_d = '0;
      end
    end

    if (frame_err) digit_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
      digit_cnt_q  <= '0;
      shreg_q      <= '0;
      date_year_q  <= '0;
      date_month_q <= '0;
      date_day_q   <= '0;
      date_valid_q <= 1'b0;
      date_match_q <= 1'b0;
    end else begin
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
      digit_cnt_q  <= digit_cnt_d;
      shreg_q      <= shreg_d;
      date_year_q  <= date_year_d;
      date_month_q <= date_month_d;
      date_day_q   <= date_day_d;
      date_valid_q <= date_valid_d;
      date_match_q <= date_match_d;
    end
  end

  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.date_year  = date_year_q;
  assign bus.date_month = date_month_q;
  assign bus.date_day   = date_day_q;
  assign bus.date_valid = date_valid_q;
  assign bus.date_match = date_match_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_birth_rx.sv
// Bench for uart_birth_rx: directed serial frames, a queue-based date model and
// a per-cycle compare process, at a shortened bit period to keep runs brief.
module tb_uart_birth_rx;

  localparam logic [11:0] BaudMax = 12'd59;
  localparam int          BitLen  = 60;
  localparam int          HalfLen = 29;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_birth_rx_if bus ();

  uart_birth_rx #(
    .baud_cnt_max(BaudMax),
    .birth_year  (16'h2000),
    .birth_month (8'h10),
    .birth_day   (8'h29)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_bytes[$];
  logic [32:0] exp_dates[$];  // {match, year, month, day}
  int          exp_err = 0;
  int          nibs[$];

  logic [15:0] cur_year  = '0;
  logic [7:0]  cur_month = '0;
  logic [7:0]  cur_day   = '0;
  logic        cur_match = 1'b0;

  int bv_cnt   = 0;
  int dv_cnt   = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what a correctly framed byte (or a bad stop bit) must produce.
  task automatic model_byte(input logic [7:0] b, input bit good);
    int y, m, d;
    logic [32:0] ent;
    if (!good) begin
      exp_err++;
      nibs.delete();
      return;
    end
    exp_bytes.push_back(b);
    if (b >= 8'h30 && b <= 8'h39) begin
      nibs.push_back(int'(b) - 48);
      if (nibs.size() == 8) begin
        y = nibs[0] * 4096 + nibs[1] * 256 + nibs[2] * 16 + nibs[3];
        m = nibs[4] * 16 + nibs[5];
        d = nibs[6] * 16 + nibs[7];
        ent = {(y == 'h2000 && m == 'h10 && d == 'h29), y[15:0], m[7:0], d[7:0]};
        exp_dates.push_back(ent);
        nibs.delete();
      end
    end else begin
      exp_err++;
      nibs.delete();
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] ent;
    if (!rst_n) begin
      cur_year  = '0;
      cur_month = '0;
      cur_day   = '0;
      cur_match = 1'b0;
      chk("outputs in reset",
          {bus.byte_data, bus.byte_valid, bus.date_year, bus.date_month, bus.date_day,
           bus.date_valid, bus.date_match, bus.err, bus.busy}, 64'd0);
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.byte_valid) begin
        bv_cnt++;
        if (exp_bytes.size() == 0) chk("spurious byte_valid", bus.byte_valid, 1'b0);
        else chk("byte_data", bus.byte_data, exp_bytes.pop_front());
      end
      if (bus.err) begin
        err_cnt++;
        chk("err pulse expected", (exp_err > 0), 1'b1);
        if (exp_err > 0) exp_err--;
      end
      if (bus.date_valid) begin
        dv_cnt++;
        if (exp_dates.size() == 0) begin
          chk("spurious date_valid", bus.date_valid, 1'b0);
        end else begin
          ent = exp_dates.pop_front();
          {cur_match, cur_year, cur_month, cur_day} = ent;
        end
      end
      chk("err/date_valid exclusive", bus.err & bus.date_valid, 1'b0);
      chk("date outputs", {bus.date_match, bus.date_year, bus.date_month, bus.date_day},
          {cur_match, cur_year, cur_month, cur_day});
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit good_stop, input int gap);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (BitLen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BitLen) @(negedge clk);
    end
    model_byte(b, good_stop);
    bus.rx = good_stop;
    repeat (BitLen) @(negedge clk);
    bus.rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, gap);
  endtask

  task automatic drain();
    int t = 0;
    int pend;
    while ((exp_bytes.size() + exp_dates.size() + exp_err) != 0 && t < 4 * BitLen) begin
      @(negedge clk);
      t++;
    end
    pend = exp_bytes.size() + exp_dates.size() + exp_err;
    chk("expected events drained", pend, 0);
    exp_bytes.delete();
    exp_dates.delete();
    exp_err = 0;
    repeat (BitLen) @(negedge clk);
  endtask

  task automatic clear_counts();
    bv_cnt  = 0;
    dv_cnt  = 0;
    err_cnt = 0;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Good birthday, back-to-back frames.
    clear_counts();
    send_str("20001029", 0);
    drain();
    chk("good: byte_valid count", bv_cnt, 8);
    chk("good: date_valid count", dv_cnt, 1);
    chk("good: err count", err_cnt, 0);
    chk("good: year", bus.date_year, 16'h2000);
    chk("good: month", bus.date_month, 8'h10);
    chk("good: day", bus.date_day, 8'h29);
    chk("good: match", bus.date_match, 1'b1);

    // Same date with long idle gaps.
    clear_counts();
    send_str("20001029", 1000);
    drain();
    chk("gap: date_valid count", dv_cnt, 1);
    chk("gap: match", bus.date_match, 1'b1);

    // Mismatching date.
    clear_counts();
    send_str("19991231", 0);
    drain();
    chk("mismatch: year", bus.date_year, 16'h1999);
    chk("mismatch: month", bus.date_month, 8'h12);
    chk("mismatch: day", bus.date_day, 8'h31);
    chk("mismatch: match", bus.date_match, 1'b0);
    chk("mismatch: date_valid count", dv_cnt, 1);

    // Glitch on idle line: false start only.
    clear_counts();
    busy_cnt = 0;
    @(negedge clk);
    bus.rx  = 1'b0;
    exp_err++;
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * BitLen) @(negedge clk);
    chk("glitch: err count", err_cnt, 1);
    chk("glitch: busy cycles", busy_cnt, HalfLen + 1);
    chk("glitch: byte_valid count", bv_cnt, 0);
    chk("glitch: back to idle", bus.busy, 1'b0);
    drain();

    // Frame error mid-date restarts digit assembly.
    clear_counts();
    send_str("200", 0);
    send_frame(8'h30, 1'b0, 0);
    send_str("20001029", 0);
    drain();
    chk("frame err: byte_valid count", bv_cnt, 11);
    chk("frame err: err count", err_cnt, 1);
    chk("frame err: date_valid count", dv_cnt, 1);
    chk("frame err: match", bus.date_match, 1'b1);

    // Non-digit character.
    clear_counts();
    send_str("2000A", 0);
    drain();
    chk("non-digit: byte_data", bus.byte_data, 8'h41);
    chk("non-digit: err count", err_cnt, 1);
    chk("non-digit: no date yet", dv_cnt, 0);
    send_str("20001029", 0);
    drain();
    chk("non-digit: date_valid count", dv_cnt, 1);
    chk("non-digit: match", bus.date_match, 1'b1);

    // Reset during data bit 4 of the third digit.
    clear_counts();
    send_str("20", 0);
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (BitLen) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 8'h30 >> i;
      repeat (BitLen) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (HalfLen) @(negedge clk);
    #2 rst_n = 1'b0;
    nibs.delete();
    repeat (20) @(negedge clk);
    chk("reset: date_year", bus.date_year, 16'h0000);
    chk("reset: busy", bus.busy, 1'b0);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    clear_counts();
    send_str("20001029", 0);
    drain();
    chk("post-reset: date_valid count", dv_cnt, 1);
    chk("post-reset: err count", err_cnt, 0);
    chk("post-reset: match", bus.date_match, 1'b1);
    chk("post-reset: year", bus.date_year, 16'h2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
